// File: rtl/lut_layer_scheduler.sv
// lut_layer_scheduler: time-shares a single external LUT port across
// NUM_NEURONS neurons. A vector is captured in IDLE, each neuron address is
// issued in turn during RUN, and the assembled result is held in DONE until
// the consumer takes it.
// Optional build macro: LUT_SCHED_LUTREG_EN registers lut_data before it is
// captured, adding one RUN cycle (the LUT path is cut by a register).
module lut_layer_scheduler #(
  parameter int NUM_NEURONS = 4,
  parameter int FANIN_BITS  = 8,
  parameter int OUT_BITS    = 2,
  localparam int SEL_BITS   = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
  localparam int IDX_BITS   = $clog2(NUM_NEURONS + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_NEURONS*FANIN_BITS-1:0] in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [SEL_BITS-1:0]             lut_sel,
  output logic [FANIN_BITS-1:0]           lut_addr,
  input  logic [OUT_BITS-1:0]             lut_data,
  output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  input  logic                            abort,
  output logic                            busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [IDX_BITS-1:0] IDX_N = IDX_BITS'(NUM_NEURONS);
`ifdef LUT_SCHED_LUTREG_EN
  // One extra RUN cycle: the last registered LUT result lands when idx == N.
  localparam logic [IDX_BITS-1:0] IDX_LAST = IDX_N;
`else
  localparam logic [IDX_BITS-1:0] IDX_LAST = IDX_BITS'(NUM_NEURONS - 1);
`endif

  state_t                state_reg;
  logic [IDX_BITS-1:0]   idx_reg;
  logic [FANIN_BITS-1:0] in_slice_reg  [NUM_NEURONS];
  logic [OUT_BITS-1:0]   out_slice_reg [NUM_NEURONS];
  logic                  out_valid_reg;
  logic                  in_ready_reg;

  logic [SEL_BITS-1:0]   sel_idx;
  logic                  issue_en;
  logic                  wr_en;
  logic [SEL_BITS-1:0]   wr_idx;
  logic [OUT_BITS-1:0]   wr_val;
  logic                  accept;

  assign sel_idx = idx_reg[SEL_BITS-1:0];
  assign accept  = in_valid & in_ready_reg & ~abort;

`ifdef LUT_SCHED_LUTREG_EN
  logic [OUT_BITS-1:0] lut_q_reg;

  assign issue_en = (state_reg == RUN) && (idx_reg != IDX_N);

  // Register the LUT result; it is written into its slice one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut_q_reg <= '0;
    end else if (issue_en) begin
      lut_q_reg <= lut_data;
    end
  end

  assign wr_en  = (state_reg == RUN) && (idx_reg != '0);
  assign wr_idx = sel_idx - SEL_BITS'(1);
  assign wr_val = lut_q_reg;
`else
  assign issue_en = (state_reg == RUN);
  assign wr_en    = (state_reg == RUN);
  assign wr_idx   = sel_idx;
  assign wr_val   = lut_data;
`endif

  // LUT port is parked at zero whenever no address is being issued.
  assign lut_sel  = issue_en ? sel_idx : '0;
  assign lut_addr = issue_en ? in_slice_reg[sel_idx] : '0;

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = (state_reg != IDLE);

  // Pack the per-neuron result slices onto the output bus.
  generate
    for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_pack
      assign out_data[gi*OUT_BITS +: OUT_BITS] = out_slice_reg[gi];
    end
  endgenerate

  // Control FSM: capture in IDLE, sweep neurons in RUN, hold result in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b0;
      for (int k = 0; k < NUM_NEURONS; k++) begin
        in_slice_reg[k]  <= '0;
        out_slice_reg[k] <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          in_ready_reg <= 1'b1;
          if (accept) begin
            for (int k = 0; k < NUM_NEURONS; k++) begin
              in_slice_reg[k] <= in_data[k*FANIN_BITS +: FANIN_BITS];
            end
            idx_reg      <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            idx_reg      <= '0;
            in_ready_reg <= 1'b1;
            state_reg    <= IDLE;
          end else begin
            if (wr_en) begin
              out_slice_reg[wr_idx] <= wr_val;
            end
            if (idx_reg == IDX_LAST) begin
              idx_reg       <= '0;
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end else begin
              idx_reg <= idx_reg + IDX_BITS'(1);
            end
          end
        end
        DONE: begin
          if (abort || out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          idx_reg       <= '0;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lut_layer_scheduler.sv
// Directed bench for lut_layer_scheduler: a 4-neuron instance with a small
// LUT model and a 1-neuron instance with its own model.
module tb_lut_layer_scheduler;

`ifdef LUT_SCHED_LUTREG_EN
  localparam int LAT4 = 6;
  localparam int LAT1 = 3;
  localparam int GAP4 = 7;
`else
  localparam int LAT4 = 5;
  localparam int LAT1 = 2;
  localparam int GAP4 = 6;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_valid, in_ready;
  logic [1:0]  lut_sel;
  logic [7:0]  lut_addr;
  logic [1:0]  lut_data;
  logic [7:0]  out_data;
  logic        out_valid, out_ready, abort, busy;

  logic [7:0]  in_data1;
  logic        in_valid1, in_ready1;
  logic [0:0]  lut_sel1;
  logic [7:0]  lut_addr1;
  logic [1:0]  lut_data1;
  logic [1:0]  out_data1;
  logic        out_valid1, out_ready1, abort1, busy1;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  lut_layer_scheduler #(.NUM_NEURONS(4), .FANIN_BITS(8), .OUT_BITS(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .lut_sel(lut_sel), .lut_addr(lut_addr),
    .lut_data(lut_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .abort(abort), .busy(busy)
  );

  lut_layer_scheduler #(.NUM_NEURONS(1), .FANIN_BITS(8), .OUT_BITS(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .lut_sel(lut_sel1), .lut_addr(lut_addr1),
    .lut_data(lut_data1), .out_data(out_data1), .out_valid(out_valid1),
    .out_ready(out_ready1), .abort(abort1), .busy(busy1)
  );

  // LUT bank model: neuron s returns addr[1:0] when it matches s,
  // otherwise addr[3:2] ^ addr[5:4].
  function automatic logic [1:0] model4(input logic [1:0] s, input logic [7:0] a);
    return (a[1:0] == s) ? a[1:0] : (a[3:2] ^ a[5:4]);
  endfunction

  always_comb lut_data  = model4(lut_sel, lut_addr);
  always_comb lut_data1 = ~lut_addr1[1:0] ^ {^lut_addr1[7:2], lut_sel1};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a vector to the 4-neuron instance; returns after the accept edge.
  task automatic send4(input logic [31:0] vec);
    in_data  = vec;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Edges counted from the accept edge (inclusive) until out_valid; -1 on timeout.
  task automatic wait_out4(output int edges);
    int n = 1;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    edges = out_valid ? n : -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_data = '0; in_valid = 0; out_ready = 1; abort = 0;
    in_data1 = '0; in_valid1 = 0; out_ready1 = 1; abort1 = 0;
    #12;
    compared++;
    if (in_ready !== 1'b0) begin mismatched++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    compared++;
    if ({out_valid, busy, out_data, lut_sel, lut_addr} !== 20'h0) begin
      mismatched++;
      $display("FAIL reset_outputs: out_valid=%b busy=%b out_data=%h lut_sel=%h lut_addr=%h want all 0",
               out_valid, busy, out_data, lut_sel, lut_addr);
    end
    rst_n = 1'b1;
    step();
    compared++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      mismatched++; $display("FAIL reset_release: in_ready=%b busy=%b want 1 0", in_ready, busy);
    end
    $display("txn reset: in_ready=%b busy=%b", in_ready, busy);
  endtask

  task automatic test_basic();
    int e;
    out_ready = 1'b1;
    send4(32'h03_C1_42_00);
    compared++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || lut_sel !== 2'd0 || lut_addr !== 8'h00) begin
      mismatched++;
      $display("FAIL basic_run_entry: busy=%b in_ready=%b sel=%h addr=%h want 1 0 0 00",
               busy, in_ready, lut_sel, lut_addr);
    end
    step(); step();
    compared++;
    if (lut_sel !== 2'd2 || lut_addr !== 8'hC1) begin
      mismatched++; $display("FAIL basic_lut_port: sel=%h addr=%h want 2 c1", lut_sel, lut_addr);
    end
    wait_out4(e);
    e += 2;
    compared++;
    if (e !== LAT4) begin mismatched++; $display("FAIL basic_latency: got %0d want %0d", e, LAT4); end
    compared++;
    if (out_data !== 8'hC0 || lut_sel !== 2'd0 || lut_addr !== 8'h00) begin
      mismatched++; $display("FAIL basic_result: out_data=%h sel=%h addr=%h want c0 0 00", out_data, lut_sel, lut_addr);
    end
    $display("txn basic: in=03c14200 out_data=%h latency=%0d", out_data, e);
    step();
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_data !== 8'hC0) begin
      mismatched++;
      $display("FAIL basic_handshake: out_valid=%b in_ready=%b busy=%b out_data=%h want 0 1 0 c0",
               out_valid, in_ready, busy, out_data);
    end
  endtask

  task automatic test_backpressure();
    int e;
    out_ready = 1'b0;
    send4(32'h11_22_33_44);
    wait_out4(e);
    compared++;
    if (e !== LAT4 || out_data !== 8'h6C) begin
      mismatched++; $display("FAIL bp_result: latency=%0d out_data=%h want %0d 6c", e, out_data, LAT4);
    end
    in_data  = 32'h0D_06_19_27;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      compared++;
      if (out_valid !== 1'b1 || out_data !== 8'h6C || in_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL bp_hold_%0d: out_valid=%b out_data=%h in_ready=%b want 1 6c 0",
                 i, out_valid, out_data, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      mismatched++; $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
    end
    $display("txn backpressure: out_data=%h held 10 cycles", out_data);
  endtask

  task automatic test_abort();
    int e;
    bit seen;
    out_ready = 1'b1;
    send4(32'h0D_06_19_27);
    step(); step();
    compared++;
    if (lut_sel !== 2'd2) begin mismatched++; $display("FAIL abort_idx: sel=%h want 2", lut_sel); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    compared++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      mismatched++; $display("FAIL abort_run: busy=%b in_ready=%b out_valid=%b want 0 1 0", busy, in_ready, out_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    compared++;
    if (seen !== 1'b0) begin mismatched++; $display("FAIL abort_no_valid: got %b want 0", seen); end
    send4(32'h30_20_10_0C);
    wait_out4(e);
    compared++;
    if (e !== LAT4 || out_data !== 8'hE4) begin
      mismatched++; $display("FAIL abort_next: latency=%0d out_data=%h want %0d e4", e, out_data, LAT4);
    end
    $display("txn abort_then_vector: out_data=%h", out_data);
    step();
    // abort in IDLE wins over in_valid
    abort = 1'b1; in_valid = 1'b1; in_data = 32'h03_C1_42_00;
    step();
    abort = 1'b0; in_valid = 1'b0;
    compared++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      mismatched++; $display("FAIL abort_idle: busy=%b in_ready=%b want 0 1", busy, in_ready);
    end
    // abort in DONE drops the result
    out_ready = 1'b0;
    send4(32'h0D_06_19_27);
    wait_out4(e);
    compared++;
    if (e !== LAT4 || out_data !== 8'hE7) begin
      mismatched++; $display("FAIL abort_done_pre: latency=%0d out_data=%h want %0d e7", e, out_data, LAT4);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    out_ready = 1'b1;
    compared++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      mismatched++; $display("FAIL abort_done: out_valid=%b busy=%b in_ready=%b want 0 0 1", out_valid, busy, in_ready);
    end
    $display("txn abort_in_done: out_valid=%b", out_valid);
  endtask

  task automatic test_reset_mid_run();
    send4(32'h11_22_33_44);
    step(); step();
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if ({out_valid, busy, in_ready, out_data, lut_sel, lut_addr} !== 21'h0) begin
      mismatched++;
      $display("FAIL rst_mid_run: out_valid=%b busy=%b in_ready=%b out_data=%h sel=%h addr=%h want all 0",
               out_valid, busy, in_ready, out_data, lut_sel, lut_addr);
    end
    step();
    compared++;
    if (in_ready !== 1'b0) begin mismatched++; $display("FAIL rst_held: in_ready=%b want 0", in_ready); end
    rst_n = 1'b1;
    step();
    compared++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      mismatched++; $display("FAIL rst_mid_release: in_ready=%b busy=%b want 1 0", in_ready, busy);
    end
    $display("txn reset_mid_run: in_ready=%b", in_ready);
  endtask

  task automatic test_back_to_back();
    int stamps[10];
    int got = 0;
    int cyc = 0;
    in_data   = 32'h30_20_10_0C;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    while (got < 10 && cyc < 400) begin
      step();
      cyc++;
      if (out_valid) begin
        stamps[got] = cyc;
        compared++;
        if (out_data !== 8'hE4) begin
          mismatched++; $display("FAIL b2b_data_%0d: got %h want e4", got, out_data);
        end
        $display("txn b2b %0d: cycle=%0d out_data=%h", got, cyc, out_data);
        got++;
        if (got == 10) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    compared++;
    if (got !== 10) begin mismatched++; $display("FAIL b2b_count: got %0d want 10", got); end
    for (int i = 1; i < got; i++) begin
      compared++;
      if (stamps[i] - stamps[i-1] !== GAP4) begin
        mismatched++; $display("FAIL b2b_gap_%0d: got %0d want %0d", i, stamps[i] - stamps[i-1], GAP4);
      end
    end
    step();
    compared++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      mismatched++; $display("FAIL b2b_idle: busy=%b in_ready=%b want 0 1", busy, in_ready);
    end
  endtask

  task automatic test_single_neuron();
    logic [7:0] vecs [2];
    logic [1:0] exps [2];
    vecs[0] = 8'h00; exps[0] = 2'b11;
    vecs[1] = 8'h02; exps[1] = 2'b01;
    out_ready1 = 1'b1;
    for (int v = 0; v < 2; v++) begin
      int n = 1;
      in_data1  = vecs[v];
      in_valid1 = 1'b1;
      step();
      in_valid1 = 1'b0;
      while (!out_valid1 && n < 20) begin
        step();
        n++;
      end
      if (!out_valid1) n = -1;
      compared++;
      if (n !== LAT1 || out_data1 !== exps[v]) begin
        mismatched++;
        $display("FAIL single_%0d: latency=%0d out_data=%b want %0d %b", v, n, out_data1, LAT1, exps[v]);
      end
      $display("txn single %0d: in=%h out_data=%b latency=%0d", v, vecs[v], out_data1, n);
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_abort();
    test_reset_mid_run();
    test_back_to_back();
    test_single_neuron();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lut_layer_scheduler.md
LUT_LAYER_SCHEDULER -- requirements
Module: lut_layer_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_NEURONS, default 4: number of neurons time-shared on one LUT port, legal range 1..256.
REQ-002 The block SHALL have parameter FANIN_BITS, default 8: LUT address width per neuron.
REQ-003 The block SHALL have parameter OUT_BITS, default 2: LUT output width per neuron.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 The block SHALL have port in_data, input, NUM_NEURONS*FANIN_BITS bits: neuron k address is slice [k*FANIN_BITS +: FANIN_BITS].
REQ-007 The block SHALL have ports in_valid (input, 1) and in_ready (output, 1): input handshake.
REQ-008 The block SHALL have port lut_sel, output, max(1,clog2(NUM_NEURONS)) bits: index of the neuron ROM selected in the external LUT bank.
REQ-009 The block SHALL have ports lut_addr (output, FANIN_BITS) and lut_data (input, OUT_BITS): LUT address and combinational LUT result.
REQ-010 The block SHALL have port out_data, output, NUM_NEURONS*OUT_BITS bits: neuron k result in slice [k*OUT_BITS +: OUT_BITS].
REQ-011 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1): output handshake.
REQ-012 The block SHALL have ports abort (input, 1, synchronous cancel) and busy (output, 1, high when the FSM is not in IDLE).

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 in_ready SHALL equal 1 only in IDLE; an accept (in_valid & in_ready) SHALL capture in_data into an internal register, clear neuron counter idx to 0, and enter RUN.
REQ-015 In RUN, lut_sel SHALL equal idx and lut_addr SHALL equal captured slice idx; lut_data SHALL be written into out_data slice idx at the same edge that idx increments.
REQ-016 When idx = NUM_NEURONS-1, the capture edge SHALL enter DONE with out_valid=1 (latency: out_valid high NUM_NEURONS+1 edges after the accept edge).
REQ-017 In DONE, out_valid and out_data SHALL hold stable until out_ready=1; the handshake edge SHALL enter IDLE.
REQ-018 out_valid SHALL be 1 only in DONE; out_data SHALL hold its value outside DONE and SHALL be overwritten slice-by-slice only in RUN.
REQ-019 Outside RUN, lut_sel and lut_addr SHALL be 0.
REQ-020 abort=1 in RUN or DONE SHALL force IDLE at the next edge, dropping out_valid and discarding the partial result; abort=1 in IDLE SHALL block acceptance that cycle (abort wins over in_valid).
REQ-021 With NUM_NEURONS=1, RUN SHALL last exactly one cycle.
REQ-022 Sustained throughput SHALL be one vector per NUM_NEURONS+2 cycles when out_ready is held at 1.

Reset
REQ-023 rst_n=0 SHALL asynchronously force state IDLE, idx=0, out_data=0, out_valid=0, busy=0, lut_sel=0 and lut_addr=0; in_ready SHALL be 0 while rst_n=0 and 1 from the first edge after release.

Configuration
REQ-024 With macro LUT_SCHED_LUTREG_EN defined, lut_data SHALL be registered before capture; RUN SHALL then last NUM_NEURONS+1 cycles, slice idx being written one edge after its address is issued, and latency SHALL be NUM_NEURONS+2; without the macro, REQ-015/016 timing SHALL apply unchanged.

Verification
REQ-025 With NUM_NEURONS=4 and LUT model = N61 table, in_data=32'h03_C1_42_00 -> out_data=8'b11_00_00_00 with out_valid asserted 5 edges after accept.
REQ-026 Backpressure test: out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0 throughout; out_ready=1 -> IDLE next edge.
REQ-027 abort pulse at idx=2 -> IDLE next edge, out_valid never asserts, and the following vector produces a correct, complete result.
REQ-028 rst_n low mid-RUN -> all outputs zero immediately (no clock edge needed), in_ready=1 one edge after release.
REQ-029 Back-to-back traffic with in_valid and out_ready held at 1 for 10 vectors -> 10 results, spacing 6 cycles (7 with LUT_SCHED_LUTREG_EN).
REQ-030 With NUM_NEURONS=1, in_data=8'h00 -> out_data=2'b11 two edges after accept.
